// File: rtl/fetch_pkg.sv
// Shared fetch-stage parameters and the {pc, inst} bundle
// carried from the fetch FIFO to decode.
package fetch_pkg;

  localparam int PC_W   = 32;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO of fetched {pc, inst} pairs.
// Ports: push/din write, pop advances head, flush empties (wins over push), count = occupancy.
module fetch_fifo2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rptr;
  logic         wptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rptr   <= 1'b0;
      wptr   <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch: owns the PC, reads the 1-cycle-latency RAM, buffers results for decode.
// Ports: mem_raddr/mem_rdata RAM side, redirect_valid/redirect_pc, out_* valid/ready to decode.
module imem_fetch
  import fetch_pkg::*;
#(
  parameter int              PC_W     = fetch_pkg::PC_W,
  parameter int              ADDR_W   = fetch_pkg::ADDR_W,
  parameter int              DATA_W   = fetch_pkg::DATA_W,
  parameter logic [PC_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_inst
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] inflight_pc;
  logic [PC_W-1:0] fetch_pc;
  logic            inflight;
  logic            pop;
  logic            push;
  logic            issue;
  logic [1:0]      count;
  logic [2:0]      occ;
  fetch_entry_t    din;
  fetch_entry_t    head;

  assign pop = out_valid && out_ready;

  // Slots that will be committed after this cycle;
  // keeps FIFO + outstanding read within 2 entries.
  assign occ = {1'b0, count} + {2'b00, inflight}
             - {2'b00, pop};

  // A redirect flushes everything, so its read always fits.
  assign issue = redirect_valid || (occ < 3'd2);

  assign fetch_pc = redirect_valid
                  ? {redirect_pc[PC_W-1:2], 2'b00}
                  : pc;

  assign mem_raddr = fetch_pc[ADDR_W+1:2];

  // Data landing during a redirect belongs to the old path.
  assign push = inflight && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        pc          <= fetch_pc + PC_W'(4);
      end
    end
  end

  assign din.pc   = inflight_pc;
  assign din.inst = mem_rdata;

  fetch_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign out_valid = (count != 2'd0);
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

endmodule
